// File: rtl/mem_result_checker.sv
// mem_result_checker: waits for the monitored CHIP pc to reach a latched
// end-of-program address, then reads data memory and answer memory in
// lock-step and reports mismatch count, first mismatching index and pass/fail.
module mem_result_checker #(
  parameter int WORD_DEPTH = 32,
  parameter int TIMEOUT    = 10000,
  localparam int IW = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1,
  localparam int EW = $clog2(WORD_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [31:0]   eof_addr,
  input  logic [31:0]   pc,
  output logic          rd_en,
  output logic [IW-1:0] rd_idx,
  input  logic [31:0]   dut_rdata,
  input  logic [31:0]   ans_rdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [EW-1:0] err_cnt,
  output logic [IW-1:0] first_err_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SCAN, S_DONE} state_t;

  state_t        state_q;
  logic [31:0]   eof_q;
  logic [31:0]   cyc_q;
  logic          rd_en_q;
  logic [IW-1:0] rd_idx_q;
  logic          cmp_vld_q;
  logic [IW-1:0] cmp_idx_q;
  logic [EW-1:0] err_q;
  logic [EW-1:0] err_d;
  logic [IW-1:0] first_q;
  logic [IW-1:0] first_d;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic          tmo_q;
  logic          mismatch;

  // Compare stage: memory data returns one cycle after the read strobe.
  always_comb begin
    mismatch = cmp_vld_q && (dut_rdata != ans_rdata);
    err_d    = err_q;
    first_d  = first_q;
    if (mismatch) begin
      if (err_q == '0) first_d = cmp_idx_q;
      if (err_q != '1) err_d = err_q + EW'(1);
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      eof_q     <= '0;
      cyc_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_idx_q  <= '0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      err_q     <= '0;
      first_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      cmp_vld_q <= rd_en_q;
      cmp_idx_q <= rd_idx_q;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_RUN;
            eof_q   <= eof_addr;
            cyc_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        S_RUN: begin
          // eof match is tested first so it wins a tie with the timeout.
          if (pc == eof_q) begin
            state_q  <= S_SCAN;
            rd_en_q  <= 1'b1;
            rd_idx_q <= '0;
          end else if (cyc_q == 32'(TIMEOUT - 1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            tmo_q   <= 1'b1;
            pass_q  <= 1'b0;
          end else begin
            cyc_q <= cyc_q + 32'd1;
          end
        end
        S_SCAN: begin
          err_q   <= err_d;
          first_q <= first_d;
          if (rd_en_q) begin
            if (rd_idx_q == IW'(WORD_DEPTH - 1)) begin
              rd_en_q  <= 1'b0;
              rd_idx_q <= '0;
            end else begin
              rd_idx_q <= rd_idx_q + IW'(1);
            end
          end
          // Last compare happens on the cycle after the final read strobe.
          if (cmp_vld_q && !rd_en_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_en         = rd_en_q;
  assign rd_idx        = rd_idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign timeout       = tmo_q;
  assign err_cnt       = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_mem_result_checker.sv
// Directed bench for mem_result_checker: three instances (default depth/
// timeout, short timeout, depth 4) sharing clock, reset, pc and eof_addr.
module tb_mem_result_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = '0;
  logic [31:0] eof_addr = '0;
  logic [31:0] pc = '0;

  logic [31:0] dmem [32];
  logic [31:0] amem [32];

  logic       rd_en_a, busy_a, done_a, pass_a, tmo_a;
  logic [4:0] rd_idx_a, first_a;
  logic [5:0] err_a;
  logic [31:0] dr_a, ar_a;
  logic       rd_en_b, busy_b, done_b, pass_b, tmo_b;
  logic [4:0] rd_idx_b, first_b;
  logic [5:0] err_b;
  logic [31:0] dr_b, ar_b;
  logic       rd_en_c, busy_c, done_c, pass_c, tmo_c;
  logic [1:0] rd_idx_c, first_c;
  logic [2:0] err_c;
  logic [31:0] dr_c, ar_c;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic       s_busy, s_done, s_pass, s_tmo, s_rd_en;
  logic [4:0] s_rd_idx, s_first;
  logic [5:0] s_err;

  always #5 clk = ~clk;

  mem_result_checker #(.WORD_DEPTH(32), .TIMEOUT(10000)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .eof_addr(eof_addr), .pc(pc),
    .rd_en(rd_en_a), .rd_idx(rd_idx_a), .dut_rdata(dr_a), .ans_rdata(ar_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .timeout(tmo_a),
    .err_cnt(err_a), .first_err_idx(first_a));

  mem_result_checker #(.WORD_DEPTH(32), .TIMEOUT(100)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .eof_addr(eof_addr), .pc(pc),
    .rd_en(rd_en_b), .rd_idx(rd_idx_b), .dut_rdata(dr_b), .ans_rdata(ar_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(tmo_b),
    .err_cnt(err_b), .first_err_idx(first_b));

  mem_result_checker #(.WORD_DEPTH(4), .TIMEOUT(100)) u_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .eof_addr(eof_addr), .pc(pc),
    .rd_en(rd_en_c), .rd_idx(rd_idx_c), .dut_rdata(dr_c), .ans_rdata(ar_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .timeout(tmo_c),
    .err_cnt(err_c), .first_err_idx(first_c));

  // Synchronous-read memory models, one read port pair per instance.
  always @(posedge clk) begin
    if (rd_en_a) begin dr_a <= dmem[rd_idx_a]; ar_a <= amem[rd_idx_a]; end
    if (rd_en_b) begin dr_b <= dmem[rd_idx_b]; ar_b <= amem[rd_idx_b]; end
    if (rd_en_c) begin dr_c <= dmem[rd_idx_c]; ar_c <= amem[rd_idx_c]; end
  end

  // Select which instance the scenario tasks observe.
  always_comb begin
    s_busy = busy_a; s_done = done_a; s_pass = pass_a; s_tmo = tmo_a;
    s_rd_en = rd_en_a; s_rd_idx = rd_idx_a; s_first = first_a; s_err = err_a;
    if (sel == 1) begin
      s_busy = busy_b; s_done = done_b; s_pass = pass_b; s_tmo = tmo_b;
      s_rd_en = rd_en_b; s_rd_idx = rd_idx_b; s_first = first_b; s_err = err_b;
    end else if (sel == 2) begin
      s_busy = busy_c; s_done = done_c; s_pass = pass_c; s_tmo = tmo_c;
      s_rd_en = rd_en_c; s_rd_idx = {3'b0, rd_idx_c};
      s_first = {3'b0, first_c}; s_err = {3'b0, err_c};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_equal;
    for (int i = 0; i < 32; i++) begin
      dmem[i] = 32'h1234_5678 ^ (32'(i) * 32'h0101_0101);
      amem[i] = dmem[i];
    end
  endtask

  // Start a run with a latched eof value, then scramble the live eof input.
  task automatic pulse_start(input logic [31:0] eof);
    eof_addr = eof;
    start_v[sel] = 1'b1;
    tick();
    start_v[sel] = 1'b0;
    eof_addr = ~eof;
  endtask

  // pc equals eof on RUN cycle n (counter value n-1); returns in first SCAN cycle.
  task automatic run_to_eof(input logic [31:0] eof, input int n);
    pc = 32'h0000_0100;
    pulse_start(eof);
    for (int k = 1; k < n; k++) begin
      pc = 32'h0000_0100 + 32'(k * 4);
      tick();
    end
    pc = eof;
    tick();
    pc = 32'h0000_0200;
  endtask

  // Follow the scan until done, optionally pulsing start at a given scan cycle.
  task automatic run_scan(input int restart_at, output int reads, output int cycles,
                          output bit order_ok);
    reads = 0; cycles = 0; order_ok = 1'b1;
    while (!s_done && cycles < 200) begin
      if (s_rd_en) begin
        if (s_rd_idx !== 5'(reads)) order_ok = 1'b0;
        reads++;
      end
      if (cycles == restart_at) start_v[sel] = 1'b1;
      tick();
      start_v[sel] = 1'b0;
      cycles++;
    end
  endtask

  task automatic test_reset;
    sel = 0;
    rst = 1'b1;
    start_v = '1;
    tick(); tick();
    start_v = '0;
    checks++;
    if ({busy_a, done_a, pass_a, tmo_a, rd_en_a} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000", {busy_a, done_a, pass_a, tmo_a, rd_en_a});
    end
    checks++;
    if (rd_idx_a !== 5'd0 || err_a !== 6'd0 || first_a !== 5'd0) begin
      errors++;
      $display("FAIL reset_values: idx=%0d err=%0d first=%0d expected 0", rd_idx_a, err_a, first_a);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy_a, done_a);
    end
  endtask

  task automatic test_match;
    int reads, cycles;
    bit ok;
    sel = 0;
    load_equal();
    run_to_eof(32'h0001_0040, 50);
    checks++;
    if (s_busy !== 1'b1 || s_rd_en !== 1'b1 || s_rd_idx !== 5'd0) begin
      errors++;
      $display("FAIL match_scan_entry: busy=%b rd_en=%b idx=%0d expected 1 1 0", s_busy, s_rd_en, s_rd_idx);
    end
    run_scan(-1, reads, cycles, ok);
    checks++;
    if (reads != 32 || !ok) begin
      errors++;
      $display("FAIL match_reads: reads=%0d order_ok=%0d expected 32 1", reads, ok);
    end
    checks++;
    if (cycles != 33) begin
      errors++;
      $display("FAIL match_latency: scan cycles=%0d expected 33", cycles);
    end
    checks++;
    if ({s_done, s_pass, s_tmo, s_busy} !== 4'b1100 || s_err !== 6'd0) begin
      errors++;
      $display("FAIL match_result: done/pass/tmo/busy=%b err=%0d expected 1100 0",
               {s_done, s_pass, s_tmo, s_busy}, s_err);
    end
    pc = 32'h0001_0040;
    tick(); tick();
    checks++;
    if (s_done !== 1'b1 || s_rd_en !== 1'b0 || s_pass !== 1'b1) begin
      errors++;
      $display("FAIL done_hold: done=%b rd_en=%b pass=%b expected 1 0 1", s_done, s_rd_en, s_pass);
    end
  endtask

  task automatic test_mismatch;
    int reads, cycles;
    bit ok;
    sel = 0;
    load_equal();
    amem[3]  = amem[3] ^ 32'h0000_0001;
    amem[17] = amem[17] ^ 32'h8000_0000;
    run_to_eof(32'h0001_0080, 7);
    run_scan(5, reads, cycles, ok);
    checks++;
    if (reads != 32 || !ok || cycles != 33) begin
      errors++;
      $display("FAIL start_ignored_in_scan: reads=%0d ok=%0d cycles=%0d expected 32 1 33", reads, ok, cycles);
    end
    checks++;
    if (s_err !== 6'd2 || s_first !== 5'd3) begin
      errors++;
      $display("FAIL mismatch_counts: err=%0d first=%0d expected 2 3", s_err, s_first);
    end
    checks++;
    if (s_done !== 1'b1 || s_pass !== 1'b0 || s_tmo !== 1'b0) begin
      errors++;
      $display("FAIL mismatch_pass: done=%b pass=%b tmo=%b expected 1 0 0", s_done, s_pass, s_tmo);
    end
  endtask

  task automatic test_reset_mid_scan;
    int reads, cycles, n;
    bit ok;
    sel = 0;
    load_equal();
    amem[2] = ~amem[2];
    run_to_eof(32'h0001_00c0, 5);
    n = 0;
    while (s_rd_idx !== 5'd10 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (s_rd_idx !== 5'd10 || s_err !== 6'd1) begin
      errors++;
      $display("FAIL pre_reset_scan: idx=%0d err=%0d expected 10 1", s_rd_idx, s_err);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({s_busy, s_done, s_pass, s_tmo, s_rd_en} !== 5'b0 || s_rd_idx !== 5'd0 ||
        s_err !== 6'd0 || s_first !== 5'd0) begin
      errors++;
      $display("FAIL mid_scan_reset: flags=%b idx=%0d err=%0d first=%0d expected 00000 0 0 0",
               {s_busy, s_done, s_pass, s_tmo, s_rd_en}, s_rd_idx, s_err, s_first);
    end
    tick();
    amem[2] = dmem[2];
    run_to_eof(32'h0001_00c0, 4);
    run_scan(-1, reads, cycles, ok);
    checks++;
    if (reads != 32 || !ok || s_pass !== 1'b1 || s_err !== 6'd0) begin
      errors++;
      $display("FAIL clean_run_after_reset: reads=%0d ok=%0d pass=%b err=%0d expected 32 1 1 0",
               reads, ok, s_pass, s_err);
    end
  endtask

  task automatic test_timeout;
    int n;
    bit seen;
    sel = 1;
    load_equal();
    pc = 32'h0;
    pulse_start(32'h0000_1000);
    n = 0;
    seen = 1'b0;
    while (!s_done && n < 300) begin
      if (s_rd_en) seen = 1'b1;
      tick();
      n++;
    end
    checks++;
    if (n != 100) begin
      errors++;
      $display("FAIL timeout_cycles: done after %0d cycles expected 100", n);
    end
    checks++;
    if ({s_done, s_tmo, s_pass, s_busy} !== 4'b1100 || seen) begin
      errors++;
      $display("FAIL timeout_result: done/tmo/pass/busy=%b rd_seen=%0d expected 1100 0",
               {s_done, s_tmo, s_pass, s_busy}, seen);
    end
  endtask

  task automatic test_tie;
    int reads, cycles;
    bit ok;
    sel = 1;
    load_equal();
    run_to_eof(32'h0002_0000, 100);
    checks++;
    if (s_busy !== 1'b1 || s_done !== 1'b0 || s_rd_en !== 1'b1 || s_tmo !== 1'b0) begin
      errors++;
      $display("FAIL tie_scan: busy=%b done=%b rd_en=%b tmo=%b expected 1 0 1 0",
               s_busy, s_done, s_rd_en, s_tmo);
    end
    run_scan(-1, reads, cycles, ok);
    checks++;
    if (reads != 32 || s_pass !== 1'b1 || s_tmo !== 1'b0) begin
      errors++;
      $display("FAIL tie_result: reads=%0d pass=%b tmo=%b expected 32 1 0", reads, s_pass, s_tmo);
    end
  endtask

  task automatic test_saturation;
    int reads, cycles;
    bit ok;
    sel = 2;
    load_equal();
    for (int i = 0; i < 4; i++) amem[i] = ~dmem[i];
    run_to_eof(32'h0000_0400, 3);
    run_scan(-1, reads, cycles, ok);
    checks++;
    if (reads != 4 || !ok || cycles != 5) begin
      errors++;
      $display("FAIL sat_scan: reads=%0d ok=%0d cycles=%0d expected 4 1 5", reads, ok, cycles);
    end
    checks++;
    if (s_err !== 6'd4 || s_first !== 5'd0 || s_pass !== 1'b0 || s_done !== 1'b1) begin
      errors++;
      $display("FAIL sat_result: err=%0d first=%0d pass=%b done=%b expected 4 0 0 1",
               s_err, s_first, s_pass, s_done);
    end
  endtask

  task automatic test_back_to_back;
    int reads, cycles;
    bit ok;
    sel = 2;
    pc = 32'h0000_0100;
    pulse_start(32'h0000_0500);
    checks++;
    if ({s_busy, s_done, s_pass, s_tmo} !== 4'b1000 || s_err !== 6'd0 || s_first !== 5'd0) begin
      errors++;
      $display("FAIL restart_clear: busy/done/pass/tmo=%b err=%0d first=%0d expected 1000 0 0",
               {s_busy, s_done, s_pass, s_tmo}, s_err, s_first);
    end
    load_equal();
    amem[1] = amem[1] ^ 32'h0001_0000;
    tick();
    pc = 32'h0000_0500;
    tick();
    pc = 32'h0;
    run_scan(-1, reads, cycles, ok);
    checks++;
    if (reads != 4 || s_err !== 6'd1 || s_first !== 5'd1 || s_pass !== 1'b0) begin
      errors++;
      $display("FAIL restart_run: reads=%0d err=%0d first=%0d pass=%b expected 4 1 1 0",
               reads, s_err, s_first, s_pass);
    end
  endtask

  initial begin
    load_equal();
    test_reset();
    test_match();
    test_mismatch();
    test_reset_mid_scan();
    test_timeout();
    test_tie();
    test_saturation();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
